// File: rtl/gpio_pattern_seq_if.sv
// Control/status bundle between the register-file wrapper (master) and the pattern sequencer (slave).
// pause is present only when GPIO_PATTERN_SEQ_PAUSE_EN is defined.
interface gpio_pattern_seq_if #(
  parameter int NUM_CH  = 34,
  parameter int PRESC_W = 14
);
  localparam int SW = $clog2(2 * NUM_CH);

  logic               en;
  logic               start;
  logic [PRESC_W-1:0] prescaler;
  logic [1:0]         mode;
  logic               oneshot;
`ifdef GPIO_PATTERN_SEQ_PAUSE_EN
  logic               pause;
`endif
  logic [NUM_CH-1:0]  pattern;
  logic               busy;
  logic               done;
  logic [SW-1:0]      step;

  modport master (
`ifdef GPIO_PATTERN_SEQ_PAUSE_EN
    output pause,
`endif
    output en, start, prescaler, mode, oneshot,
    input  pattern, busy, done, step
  );

  modport slave (
`ifdef GPIO_PATTERN_SEQ_PAUSE_EN
    input  pause,
`endif
    input  en, start, prescaler, mode, oneshot,
    output pattern, busy, done, step
  );
endinterface

// File: rtl/gpio_pattern_seq.sv
// gpio_pattern_seq: NUM_CH-channel walking/ping-pong/binary pattern sequencer; pause input exists with GPIO_PATTERN_SEQ_PAUSE_EN.
// Latency: first step P*TICKS_PER_UNIT cycles after go is sampled; no backpressure, en/start deassert aborts to IDLE next edge.
module gpio_pattern_seq #(
  parameter int NUM_CH         = 34,
  parameter int PRESC_W        = 14,
  parameter int TICKS_PER_UNIT = 10000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  gpio_pattern_seq_if.slave bus
);

  localparam int SW    = $clog2(2 * NUM_CH);
  localparam int TW    = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int BIN_W = (NUM_CH < 16) ? NUM_CH : 16;

  localparam logic [16:0] BIN_MOD   = 17'(1) << BIN_W;
  localparam logic [15:0] LEN_SHIFT = 16'(NUM_CH);
  localparam logic [15:0] LEN_PP    = 16'(2 * NUM_CH - 1);
  localparam logic [15:0] LEN_BIN   = 16'(BIN_MOD - 17'd1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [TW-1:0]      tick_cnt;
  logic [PRESC_W-1:0] unit_cnt;
  logic [PRESC_W-1:0] presc_q;
  logic [1:0]         mode_q;
  logic [15:0]        step_q;
  logic [NUM_CH-1:0]  pattern_q;
  logic               busy_q;
  logic               done_q;

  logic run_ok;
  logic go;
  logic hold;
  logic tick_last;
  logic unit_last;
  logic seq_end;

  function automatic logic [15:0] seq_len(input logic [1:0] m);
    case (m)
      2'b00, 2'b01: seq_len = LEN_SHIFT;
      2'b10:        seq_len = LEN_PP;
      default:      seq_len = LEN_BIN;
    endcase
  endfunction

  // k is 1-based; ping-pong reflects back down after reaching the top channel
  function automatic logic [NUM_CH-1:0] pat_of(input logic [1:0] m, input logic [15:0] k);
    logic [NUM_CH-1:0] one;
    logic [63:0]       kx;
    one = NUM_CH'(1);
    kx  = 64'(k);
    case (m)
      2'b00:   pat_of = one << (k - 16'd1);
      2'b01:   pat_of = one << (LEN_SHIFT - k);
      2'b10:   pat_of = (k <= LEN_SHIFT) ? (one << (k - 16'd1)) : (one << (LEN_PP - k));
      default: pat_of = kx[NUM_CH-1:0];
    endcase
  endfunction

  assign run_ok    = bus.en & bus.start;
  assign go        = run_ok & (bus.prescaler != '0);
  assign tick_last = (tick_cnt == TICK_LAST);
  assign unit_last = (unit_cnt == presc_q - PRESC_W'(1));
  assign seq_end   = (step_q == seq_len(mode_q));
`ifdef GPIO_PATTERN_SEQ_PAUSE_EN
  assign hold      = bus.pause;
`else
  assign hold      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      unit_cnt  <= '0;
      presc_q   <= '0;
      mode_q    <= '0;
      step_q    <= '0;
      pattern_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          pattern_q <= '0;
          if (go) begin
            presc_q  <= bus.prescaler;
            mode_q   <= bus.mode;
            tick_cnt <= '0;
            unit_cnt <= '0;
            step_q   <= '0;
            busy_q   <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!run_ok) begin
            state     <= ST_IDLE;
            pattern_q <= '0;
            tick_cnt  <= '0;
            unit_cnt  <= '0;
            step_q    <= '0;
            busy_q    <= 1'b0;
          end else if (!hold) begin
            if (!tick_last) begin
              tick_cnt <= tick_cnt + TW'(1);
            end else begin
              tick_cnt <= '0;
              if (!unit_last) begin
                unit_cnt <= unit_cnt + PRESC_W'(1);
              end else begin
                unit_cnt <= '0;
                if (seq_end) begin
                  pattern_q <= '0;
                  done_q    <= 1'b1;
                  step_q    <= '0;
                  if (bus.oneshot) begin
                    state  <= ST_DONE;
                    busy_q <= 1'b0;
                  end else if (bus.prescaler == '0) begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                  end else begin
                    presc_q <= bus.prescaler;
                    mode_q  <= bus.mode;
                  end
                end else begin
                  step_q    <= step_q + 16'd1;
                  pattern_q <= pat_of(mode_q, step_q + 16'd1);
                end
              end
            end
          end
        end
        ST_DONE: begin
          pattern_q <= '0;
          if (!run_ok) state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pattern = pattern_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.step    = step_q[SW-1:0];

endmodule

// File: tb/tb_gpio_pattern_seq.sv
// Bench for gpio_pattern_seq (NUM_CH=4, TICKS_PER_UNIT=10): directed scenarios plus random traffic against a step-list model.
// Build with GPIO_PATTERN_SEQ_PAUSE_EN defined to include the pause scenario.
module tb_gpio_pattern_seq;

  localparam int N  = 4;
  localparam int PW = 4;
  localparam int T  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_pattern_seq_if #(.NUM_CH(N), .PRESC_W(PW)) bus ();

  gpio_pattern_seq #(.NUM_CH(N), .PRESC_W(PW), .TICKS_PER_UNIT(T)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state: 0 idle, 1 run, 2 done; m_left counts cycles to the next step
  int         m_st = 0;
  int         m_mode = 0;
  int         m_p = 0;
  int         m_k = 0;
  int         m_left = 0;
  logic [N-1:0] e_pat = '0;
  logic       e_busy = 1'b0;
  logic       e_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mlen(input int m);
    if (m < 2) return N;
    if (m == 2) return 2 * N - 1;
    return (1 << N) - 1;
  endfunction

  function automatic logic [N-1:0] mpat(input int m, input int k);
    int v;
    case (m)
      0: v = 1 << (k - 1);
      1: v = 1 << (N - k);
      2: v = (k <= N) ? (1 << (k - 1)) : (1 << (2 * N - 1 - k));
      default: v = k % (1 << N);
    endcase
    return v[N-1:0];
  endfunction

  task automatic model_edge();
    bit run_ok;
    bit hold;
    run_ok = bus.en && bus.start;
`ifdef GPIO_PATTERN_SEQ_PAUSE_EN
    hold = bus.pause;
`else
    hold = 1'b0;
`endif
    e_done = 1'b0;
    if (rst) begin
      m_st = 0; e_pat = '0; e_busy = 1'b0; m_k = 0;
    end else if (m_st == 0) begin
      if (run_ok && bus.prescaler != 0) begin
        m_st = 1; m_mode = int'(bus.mode); m_p = int'(bus.prescaler);
        m_k = 0; m_left = m_p * T; e_busy = 1'b1;
      end
    end else if (m_st == 1) begin
      if (!run_ok) begin
        m_st = 0; e_pat = '0; m_k = 0; e_busy = 1'b0;
      end else if (!hold) begin
        m_left--;
        if (m_left == 0) begin
          if (m_k == mlen(m_mode)) begin
            e_pat = '0; e_done = 1'b1; m_k = 0;
            if (bus.oneshot) begin
              m_st = 2; e_busy = 1'b0;
            end else if (bus.prescaler == 0) begin
              m_st = 0; e_busy = 1'b0;
            end else begin
              m_mode = int'(bus.mode); m_p = int'(bus.prescaler); m_left = m_p * T;
            end
          end else begin
            m_k++;
            e_pat = mpat(m_mode, m_k);
            m_left = m_p * T;
          end
        end
      end
    end else begin
      e_pat = '0;
      if (!run_ok) m_st = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("pattern", 64'(bus.pattern), 64'(e_pat));
    check("busy", 64'(bus.busy), 64'(e_busy));
    check("done", 64'(bus.done), 64'(e_done));
    check("step", 64'(bus.step), 64'(m_k % 8));
  endtask

  task automatic idle_for(input int n);
    bus.start = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int at;
    bus.en = 1'b0; bus.start = 1'b0; bus.prescaler = '0; bus.mode = '0; bus.oneshot = 1'b0;
`ifdef GPIO_PATTERN_SEQ_PAUSE_EN
    bus.pause = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) tick();
    check("reset_pattern", 64'(bus.pattern), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;

    // prescaler 0 never starts
    bus.en = 1'b1; bus.start = 1'b1; bus.prescaler = 4'd0;
    at = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.done || bus.busy) at = i;
    end
    check("p0_no_activity", 64'(at), 64'hFFFF_FFFF_FFFF_FFFF);

    // shift-up, P=2, continuous
    idle_for(2);
    bus.mode = 2'b00; bus.prescaler = 4'd2; bus.oneshot = 1'b0; bus.start = 1'b1;
    at = -1;
    for (int i = 1; i <= 130; i++) begin
      tick();
      if (i == 20) check("su_before_first", 64'(bus.pattern), 64'd0);
      if (i == 21) check("su_first", 64'(bus.pattern), 64'd1);
      if (i == 81) check("su_top", 64'(bus.pattern), 64'h8);
      if (i == 121) check("su_wrap", 64'(bus.pattern), 64'd1);
      if (bus.done && at < 0) at = i;
    end
    check("su_done_edge", 64'(at), 64'd101);

    // ping-pong, P=1, one-shot
    idle_for(2);
    bus.mode = 2'b10; bus.prescaler = 4'd1; bus.oneshot = 1'b1; bus.start = 1'b1;
    at = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 51) check("pp_return", 64'(bus.pattern), 64'h4);
      if (bus.done && at < 0) at = i;
    end
    check("pp_done_edge", 64'(at), 64'd81);
    check("pp_done_busy", 64'(bus.busy), 64'd0);
    idle_for(3);

    // binary, P=1
    bus.mode = 2'b11; bus.prescaler = 4'd1; bus.oneshot = 1'b0; bus.start = 1'b1;
    at = -1;
    for (int i = 1; i <= 170; i++) begin
      tick();
      if (i == 151) check("bin_15", 64'(bus.pattern), 64'hF);
      if (bus.done && at < 0) at = i;
    end
    check("bin_done_edge", 64'(at), 64'd161);
    idle_for(2);

    // shift-down, P=3, abort mid-sequence then restart with a mid-sequence prescaler change
    bus.mode = 2'b01; bus.prescaler = 4'd3; bus.oneshot = 1'b0; bus.start = 1'b1;
    repeat (65) tick();
    bus.start = 1'b0;
    tick();
    check("sd_abort_pat", 64'(bus.pattern), 64'd0);
    check("sd_abort_busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      if (i == 40) bus.prescaler = 4'd1;
      tick();
      if (i == 31) check("sd_restart", 64'(bus.pattern), 64'h8);
      if (i == 91) check("sd_period_kept", 64'(bus.pattern), 64'h2);
    end
    idle_for(2);

`ifdef GPIO_PATTERN_SEQ_PAUSE_EN
    bus.mode = 2'b00; bus.prescaler = 4'd1; bus.oneshot = 1'b0; bus.start = 1'b1;
    at = -1;
    for (int i = 1; i <= 80; i++) begin
      bus.pause = (i >= 16 && i <= 52);
      tick();
      if (bus.pattern == 4'h2 && at < 0) at = i;
    end
    check("pause_shift", 64'(at), 64'd58);
    bus.pause = 1'b0;
    idle_for(2);
`endif

    // random traffic
    bus.start = 1'b1; bus.prescaler = 4'd1;
    for (int i = 0; i < 15000; i++) begin
      rst = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 499) == 0) bus.en = ~bus.en;
      if (!bus.en && $urandom_range(0, 19) == 0) bus.en = 1'b1;
      if ($urandom_range(0, 149) == 0) bus.start = ~bus.start;
      if (!bus.start && $urandom_range(0, 9) == 0) bus.start = 1'b1;
      if ($urandom_range(0, 99) == 0) bus.prescaler = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) bus.oneshot = ~bus.oneshot;
`ifdef GPIO_PATTERN_SEQ_PAUSE_EN
      if ($urandom_range(0, 39) == 0) bus.pause = ~bus.pause;
`endif
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
